ahb_uart_tx: RTL and testbench

AHB-Lite slave transmit UART that replaces the simulation-only console as the CPU's character output path. Byte writes from the Cortex-M0 go into a small FIFO, and the FIFO drains through an 8N1 serializer on TXD. The block sits on the AHB-Lite bus beside the RAM, is selected by the system address decoder, and needs zero wait states.

---
 rtl/ahb_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_ahb_uart_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_uart_tx.sv
// AHB-Lite transmit-only UART: zero-wait-state register slave feeding a byte FIFO
// that drains through an 8N1 serializer on TXD.
module ahb_uart_tx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] BAUD_RESET = 16'd3
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [3:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        TXD,
  output logic        TX_BUSY
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  logic        ap_valid_q, ap_write_q;
  logic [1:0]  ap_idx_q;
  logic        data_wr, stat_wr, baud_wr, rd_en;
  logic [AW:0] wr_ptr_q, rd_ptr_q, level;
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [7:0]  fifo_rdata;
  logic        full, empty, push, pop;
  logic        overflow_q;
  logic [15:0] bauddiv_q;
  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic        txd_q, txd_d;
  logic        bit_done;
  logic [4:0]  level5;
  logic        unused_ok;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign unused_ok = ^{HSIZE, HADDR[1:0], HWDATA[31:16]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ap_valid_q <= 1'b0;
      ap_write_q <= 1'b0;
      ap_idx_q   <= 2'd0;
    end else if (HREADY) begin
      ap_valid_q <= HSEL & HTRANS[1];
      ap_write_q <= HWRITE;
      ap_idx_q   <= HADDR[3:2];
    end
  end

  assign data_wr = ap_valid_q & ap_write_q & (ap_idx_q == 2'd0);
  assign stat_wr = ap_valid_q & ap_write_q & (ap_idx_q == 2'd1);
  assign baud_wr = ap_valid_q & ap_write_q & (ap_idx_q == 2'd2);
  assign rd_en   = ap_valid_q & ~ap_write_q;

  assign level      = wr_ptr_q - rd_ptr_q;
  assign full       = (level == FULL_LVL);
  assign empty      = (level == '0);
  assign push       = data_wr & ~full;
  assign fifo_rdata = fifo_mem[rd_ptr_q[AW-1:0]];

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge HCLK) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= HWDATA[7:0];
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      bauddiv_q  <= BAUD_RESET;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (data_wr & full)           overflow_q <= 1'b1;
      else if (stat_wr & HWDATA[3]) overflow_q <= 1'b0;
      if (baud_wr) bauddiv_q <= HWDATA[15:0];
    end
  end

  assign bit_done = (baud_cnt_q == 16'd0);

  // NOTE: every signal driven here gets a default first, so no latches are inferred.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    baud_cnt_d = baud_cnt_q;
    txd_d      = txd_q;
    pop        = 1'b0;
    if (state_q != S_IDLE && !bit_done) begin
      baud_cnt_d = baud_cnt_q - 16'd1;
    end else begin
      // BAUDDIV is only sampled here, at a bit boundary.
      case (state_q)
        S_IDLE, S_STOP: begin
          if (!empty) begin
            pop        = 1'b1;
            state_d    = S_START;
            shift_d    = fifo_rdata;
            txd_d      = 1'b0;
            baud_cnt_d = bauddiv_q;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_START: begin
          state_d    = S_DATA;
          txd_d      = shift_q[0];
          shift_d    = {1'b0, shift_q[7:1]};
          bit_idx_d  = 3'd0;
          baud_cnt_d = bauddiv_q;
        end
        S_DATA: begin
          baud_cnt_d = bauddiv_q;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            txd_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      shift_q    <= 8'd0;
      bit_idx_q  <= 3'd0;
      baud_cnt_q <= 16'd0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      txd_q      <= txd_d;
    end
  end

  assign TXD     = txd_q;
  assign TX_BUSY = ~empty | (state_q != S_IDLE);
  assign level5  = 5'(level);

  always_comb begin
    HRDATA = 32'd0;
    if (rd_en) begin
      case (ap_idx_q)
        2'd1:    HRDATA = {23'd0, level5, overflow_q, TX_BUSY, empty, full};
        2'd2:    HRDATA = {16'd0, bauddiv_q};
        default: HRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_uart_tx.sv
// Directed bench for ahb_uart_tx: register access, frame timing on TXD,
// overflow, back-to-back frames, baud change and asynchronous reset.
module tb_ahb_uart_tx;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [3:0]  HADDR = 4'd0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd2;
  logic [31:0] HWDATA = 32'd0;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA;
  logic        HREADYOUT, HRESP, TXD, TX_BUSY;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  ahb_uart_tx #(.FIFO_DEPTH(8), .BAUD_RESET(16'd3)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .TXD(TXD), .TX_BUSY(TX_BUSY)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expd);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    tick();
  endtask

  // Returns during the data-phase cycle; HRDATA is combinational there.
  task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00;
    data = HRDATA;
  endtask

  function automatic logic exp_txd(input logic [7:0] b, input int k, input int first_len,
                                   input int rest_len);
    int j;
    if (k < first_len) return 1'b0;
    j = (k - first_len) / rest_len;
    if (j < 8) return b[j];
    return 1'b1;
  endfunction

  // k counts cycles since the edge where TXD fell; the caller sits at cycle k0.
  task automatic check_frame(input string tag, input logic [7:0] b, input int k0,
                             input int first_len, input int rest_len);
    for (int k = k0; k < first_len + 9 * rest_len; k++) begin
      check($sformatf("%s txd k=%0d", tag, k), {31'd0, TXD},
            {31'd0, exp_txd(b, k, first_len, rest_len)});
      tick();
    end
  endtask

  initial begin
    logic [31:0] rd;
    int t0;
    int n;

    repeat (3) tick();
    check("rst txd", {31'd0, TXD}, 32'd1);
    check("rst busy", {31'd0, TX_BUSY}, 32'd0);
    check("rst hrdata", HRDATA, 32'd0);
    check("rst hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("rst hresp", {31'd0, HRESP}, 32'd0);
    HRESET = 1'b0;
    tick();

    bus_read(4'h4, rd); check("idle status", rd, 32'h0000_0002);
    check("idle txd", {31'd0, TXD}, 32'd1);
    bus_read(4'h8, rd); check("idle bauddiv", rd, 32'h0000_0003);
    bus_read(4'h0, rd); check("data reads 0", rd, 32'd0);
    bus_write(4'hC, 32'hFFFF_FFFF);
    bus_read(4'hC, rd); check("reg C reads 0", rd, 32'd0);
    bus_write(4'h8, 32'hABCD_1234);
    bus_read(4'h8, rd); check("bauddiv upper 0", rd, 32'h0000_1234);
    bus_write(4'h8, 32'd3);
    bus_read(4'h8, rd); check("bauddiv restore", rd, 32'h0000_0003);

    // Single byte 0x41 at 4 cycles per bit.
    bus_write(4'h0, 32'h41);
    check("single pre txd", {31'd0, TXD}, 32'd1);
    check("single pre busy", {31'd0, TX_BUSY}, 32'd1);
    tick();
    check_frame("single", 8'h41, 0, 4, 4);
    check("single end busy", {31'd0, TX_BUSY}, 32'd0);
    check("single end txd", {31'd0, TXD}, 32'd1);
    bus_read(4'h4, rd); check("single status", rd, 32'h0000_0002);

    // Back-to-back frames, no idle gap.
    bus_write(4'h0, 32'h55);
    tick();
    check("b2b start", {31'd0, TXD}, 32'd0);
    bus_write(4'h0, 32'hAA);
    check_frame("b2b first", 8'h55, 2, 4, 4);
    check_frame("b2b second", 8'hAA, 0, 4, 4);
    check("b2b end busy", {31'd0, TX_BUSY}, 32'd0);

    // Baud change during the start bit: start keeps 4 cycles, later bits take 8.
    bus_write(4'h0, 32'hC3);
    tick();
    check("baud start", {31'd0, TXD}, 32'd0);
    tick();
    bus_write(4'h8, 32'd7);
    check_frame("baud", 8'hC3, 3, 4, 8);
    check("baud end busy", {31'd0, TX_BUSY}, 32'd0);
    bus_write(4'h8, 32'd3);

    // Overflow: 10 back-to-back writes at BAUDDIV=100 -> 9 frames.
    bus_write(4'h8, 32'd100);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 4'h0;
    t0 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) t0 = cyc;
      HWDATA = 32'h30 + 32'(i);
      if (i == 9) begin
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
      end
    end
    tick();
    bus_read(4'h4, rd); check("ovf status", rd, 32'h0000_008D);
    bus_write(4'h4, 32'hFFFF_FFF7);
    bus_read(4'h4, rd); check("ovf kept", rd, 32'h0000_008D);
    bus_write(4'h4, 32'h0000_0008);
    bus_read(4'h4, rd); check("ovf cleared", rd, 32'h0000_0085);
    n = 0;
    while (TX_BUSY !== 1'b0 && n < 12000) begin
      tick();
      n++;
    end
    check("ovf busy falls", {31'd0, TX_BUSY}, 32'd0);
    check("ovf 9 frames cycles", 32'(cyc - t0), 32'd9092);
    check("ovf end txd", {31'd0, TXD}, 32'd1);
    bus_write(4'h8, 32'd3);

    // Asynchronous reset during data bit 3 (period 5 cycles).
    bus_write(4'h8, 32'd4);
    bus_write(4'h0, 32'h41);
    bus_write(4'h0, 32'h42);
    repeat (21) tick();
    check("rstmid bit3", {31'd0, TXD}, 32'd0);
    check("rstmid busy", {31'd0, TX_BUSY}, 32'd1);
    #2;
    HRESET = 1'b1;
    #1;
    check("rstmid txd", {31'd0, TXD}, 32'd1);
    check("rstmid busy low", {31'd0, TX_BUSY}, 32'd0);
    tick();
    HRESET = 1'b0;
    tick();
    bus_read(4'h4, rd); check("rstmid status", rd, 32'h0000_0002);
    bus_read(4'h8, rd); check("rstmid bauddiv", rd, 32'h0000_0003);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rstmid idle txd", {31'd0, TXD}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
